ux607_tlarbiter_qspi: RTL and testbench

//  Two-requester TileLink-UL arbiter sharing one 8-bit QSPI slave port (30-bit address).

---
 rtl/ux607_tlarbiter_qspi_if.sv | 37 +++
 rtl/ux607_tlarbiter_qspi.sv | 167 ++++++++++++++++
 tb/tb_ux607_tlarbiter_qspi.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ux607_tlarbiter_qspi_if.sv
// TileLink-UL A/D channel bundle for one port of the QSPI arbiter.
// SRC_W sizes the source field on both channels.
interface ux607_tlarbiter_qspi_if #(parameter int SRC_W = 2) ();
    logic             a_ready;
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [2:0]       a_size;
    logic [SRC_W-1:0] a_source;
    logic [29:0]      a_address;
    logic             a_mask;
    logic [7:0]       a_data;
    logic             d_ready;
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [1:0]       d_param;
    logic [2:0]       d_size;
    logic [SRC_W-1:0] d_source;
    logic             d_sink;
    logic             d_addr_lo;
    logic [7:0]       d_data;
    logic             d_error;

    modport master (
        input  a_ready,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output d_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error
    );

    modport slave (
        output a_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  d_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_addr_lo, d_data, d_error
    );
endinterface

// File: rtl/ux607_tlarbiter_qspi.sv
// Two-requester TileLink-UL arbiter in front of the 8-bit QSPI port: round-robin
// grant locked across Put bursts, source tagging, D routing and in-flight caps.
module ux607_tlarbiter_qspi #(
    parameter int MAX_INFLIGHT = 2,
    parameter int MAX_SIZE     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ux607_tlarbiter_qspi_if.slave  in0_io,
    ux607_tlarbiter_qspi_if.slave  in1_io,
    ux607_tlarbiter_qspi_if.master out_io
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam int         BEAT_W       = MAX_SIZE + 1;
    localparam logic [1:0] INFLIGHT_CAP = 2'(MAX_INFLIGHT);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_q, rr_d;
    logic [BEAT_W-1:0] a_beat_q, a_beat_d;
    logic [BEAT_W-1:0] d_beat_q, d_beat_d;

    logic              sel, any_req, a_fire, a_last, has_data;
    logic              d_sel, d_fire, d_last;
    logic [7:0]        a_full, d_full;
    logic [BEAT_W-1:0] a_beats_m1, d_beats_m1;
    logic [1:0]        req_valid, elig, inc, dec;

    assign req_valid = {in1_io.a_valid, in0_io.a_valid};

    // Combinational outputs are forced quiet while reset is held.
    always_comb begin
        sel     = 1'b0;
        any_req = 1'b0;
        if (state_q == BURST) begin
            sel     = grant_q;
            any_req = req_valid[grant_q];
        end else begin
            sel     = (elig == 2'b11) ? rr_q : elig[1];
            any_req = |elig;
        end
        any_req = any_req && rst_n;
    end

    assign out_io.a_valid   = any_req;
    assign out_io.a_opcode  = sel ? in1_io.a_opcode  : in0_io.a_opcode;
    assign out_io.a_param   = sel ? in1_io.a_param   : in0_io.a_param;
    assign out_io.a_size    = sel ? in1_io.a_size    : in0_io.a_size;
    assign out_io.a_source  = {sel, (sel ? in1_io.a_source : in0_io.a_source)};
    assign out_io.a_address = sel ? in1_io.a_address : in0_io.a_address;
    assign out_io.a_mask    = sel ? in1_io.a_mask    : in0_io.a_mask;
    assign out_io.a_data    = sel ? in1_io.a_data    : in0_io.a_data;
    assign in0_io.a_ready   = any_req && !sel && out_io.a_ready;
    assign in1_io.a_ready   = any_req &&  sel && out_io.a_ready;

    assign a_fire     = any_req && out_io.a_ready;
    assign has_data   = !out_io.a_opcode[2];
    assign a_full     = 8'd1 << out_io.a_size;
    assign a_beats_m1 = has_data ? BEAT_W'(a_full - 8'd1) : '0;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        a_beat_d = a_beat_q;
        a_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    if (a_beats_m1 != '0) begin
                        state_d  = BURST;
                        grant_d  = sel;
                        a_beat_d = a_beats_m1;
                    end else begin
                        rr_d   = ~sel;
                        a_last = 1'b1;
                    end
                end
            end
            BURST: begin
                if (a_fire) begin
                    if (a_beat_q == BEAT_W'(1)) begin
                        state_d  = IDLE;
                        rr_d     = ~grant_q;
                        a_beat_d = '0;
                        a_last   = 1'b1;
                    end else begin
                        a_beat_d = a_beat_q - BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // D channel: the tag bit in the slave source picks the requester.
    assign d_sel          = out_io.d_source[2];
    assign in0_io.d_valid = rst_n && out_io.d_valid && !d_sel;
    assign in1_io.d_valid = rst_n && out_io.d_valid &&  d_sel;
    assign out_io.d_ready = rst_n && (d_sel ? in1_io.d_ready : in0_io.d_ready);

    assign in0_io.d_opcode  = out_io.d_opcode;
    assign in0_io.d_param   = out_io.d_param;
    assign in0_io.d_size    = out_io.d_size;
    assign in0_io.d_source  = out_io.d_source[1:0];
    assign in0_io.d_sink    = out_io.d_sink;
    assign in0_io.d_addr_lo = out_io.d_addr_lo;
    assign in0_io.d_data    = out_io.d_data;
    assign in0_io.d_error   = out_io.d_error;
    assign in1_io.d_opcode  = out_io.d_opcode;
    assign in1_io.d_param   = out_io.d_param;
    assign in1_io.d_size    = out_io.d_size;
    assign in1_io.d_source  = out_io.d_source[1:0];
    assign in1_io.d_sink    = out_io.d_sink;
    assign in1_io.d_addr_lo = out_io.d_addr_lo;
    assign in1_io.d_data    = out_io.d_data;
    assign in1_io.d_error   = out_io.d_error;

    assign d_fire     = out_io.d_valid && out_io.d_ready;
    assign d_full     = 8'd1 << out_io.d_size;
    assign d_beats_m1 = (out_io.d_opcode == 3'd1) ? BEAT_W'(d_full - 8'd1) : '0;
    assign d_last     = d_fire && (d_beat_q == d_beats_m1);
    assign d_beat_d   = !d_fire ? d_beat_q : (d_last ? '0 : d_beat_q + BEAT_W'(1));

    for (genvar gi = 0; gi < 2; gi++) begin : g_inflight
        logic [1:0] cnt_q, cnt_d;

        assign elig[gi] = req_valid[gi] && (cnt_q < INFLIGHT_CAP);
        assign inc[gi]  = a_last && (sel == 1'(gi));
        assign dec[gi]  = d_last && (d_sel == 1'(gi));

        // A response with nothing outstanding saturates at zero.
        always_comb begin
            cnt_d = cnt_q;
            if (inc[gi] && !dec[gi]) begin
                cnt_d = cnt_q + 2'd1;
            end else if (dec[gi] && !inc[gi] && (cnt_q != 2'd0)) begin
                cnt_d = cnt_q - 2'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            rr_q     <= 1'b0;
            a_beat_q <= '0;
            d_beat_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            a_beat_q <= a_beat_d;
            d_beat_q <= d_beat_d;
        end
    end
endmodule

// File: tb/tb_ux607_tlarbiter_qspi.sv
// Scenario bench for the two-requester QSPI arbiter: A/D scoreboards plus
// per-scenario inline checks of grant, lock, in-flight cap and reset behaviour.
module tb_ux607_tlarbiter_qspi;
    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    typedef struct packed {
        logic [2:0]  src;
        logic [29:0] addr;
        logic [7:0]  data;
    } a_exp_t;

    typedef struct packed {
        logic       port;
        logic [1:0] src;
        logic [2:0] opc;
        logic [7:0] data;
    } d_exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     checks = 0;
    int     errors = 0;
    a_exp_t a_q[$];
    d_exp_t d_q[$];

    always #5 clk = ~clk;

    ux607_tlarbiter_qspi_if #(.SRC_W(2)) in0_if ();
    ux607_tlarbiter_qspi_if #(.SRC_W(2)) in1_if ();
    ux607_tlarbiter_qspi_if #(.SRC_W(3)) out_if ();

    ux607_tlarbiter_qspi #(.MAX_INFLIGHT(2), .MAX_SIZE(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in0_io (in0_if),
        .in1_io (in1_if),
        .out_io (out_if)
    );

    function automatic a_exp_t mk_a(input logic [2:0] src, input logic [29:0] addr, input logic [7:0] data);
        a_exp_t e;
        e.src  = src;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    function automatic d_exp_t mk_d(input logic [2:0] src, input logic [2:0] opc, input logic [7:0] data);
        d_exp_t e;
        e.port = src[2];
        e.src  = src[1:0];
        e.opc  = opc;
        e.data = data;
        return e;
    endfunction

    task automatic drive_a(input int n, input logic v, input logic [2:0] opc, input logic [2:0] size,
                           input logic [1:0] src, input logic [29:0] addr, input logic [7:0] data);
        if (n == 0) begin
            in0_if.a_valid = v; in0_if.a_opcode = opc; in0_if.a_size = size;
            in0_if.a_source = src; in0_if.a_address = addr; in0_if.a_data = data;
        end else begin
            in1_if.a_valid = v; in1_if.a_opcode = opc; in1_if.a_size = size;
            in1_if.a_source = src; in1_if.a_address = addr; in1_if.a_data = data;
        end
    endtask

    task automatic sb_a_step();
        a_exp_t e;
        if (out_if.a_valid && out_if.a_ready) begin
            checks++;
            if (a_q.size() == 0) begin
                errors++;
                $display("FAIL sb_a unexpected beat src=%0h addr=%0h data=%0h", out_if.a_source, out_if.a_address, out_if.a_data);
            end else begin
                e = a_q.pop_front();
                if (out_if.a_source !== e.src || out_if.a_address !== e.addr || out_if.a_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_a got src=%0h addr=%0h data=%0h want src=%0h addr=%0h data=%0h",
                             out_if.a_source, out_if.a_address, out_if.a_data, e.src, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic sb_d_step();
        d_exp_t e;
        if (in0_if.d_valid && in0_if.d_ready) begin
            checks++;
            e = (d_q.size() != 0) ? d_q.pop_front() : '1;
            if (e.port !== 1'b0 || in0_if.d_source !== e.src || in0_if.d_opcode !== e.opc || in0_if.d_data !== e.data) begin
                errors++;
                $display("FAIL sb_d in0 got src=%0h opc=%0h data=%0h want port=%0d src=%0h opc=%0h data=%0h",
                         in0_if.d_source, in0_if.d_opcode, in0_if.d_data, e.port, e.src, e.opc, e.data);
            end
        end
        if (in1_if.d_valid && in1_if.d_ready) begin
            checks++;
            e = (d_q.size() != 0) ? d_q.pop_front() : '0;
            if (e.port !== 1'b1 || in1_if.d_source !== e.src || in1_if.d_opcode !== e.opc || in1_if.d_data !== e.data) begin
                errors++;
                $display("FAIL sb_d in1 got src=%0h opc=%0h data=%0h want port=%0d src=%0h opc=%0h data=%0h",
                         in1_if.d_source, in1_if.d_opcode, in1_if.d_data, e.port, e.src, e.opc, e.data);
            end
        end
    endtask

    // Drives one full slave response; both requesters' d_ready are assumed high.
    task automatic send_d(input logic [2:0] src, input logic [2:0] opc, input logic [2:0] size, input logic [7:0] data0);
        int total = (opc == OP_ACKD) ? (1 << size) : 1;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            out_if.d_valid = 1'b1; out_if.d_opcode = opc; out_if.d_size = size;
            out_if.d_source = src; out_if.d_data = data0 + 8'(i);
            d_q.push_back(mk_d(src, opc, data0 + 8'(i)));
            #1;
            checks++;
            if ((src[2] ? {in1_if.d_valid, in0_if.d_valid} : {in0_if.d_valid, in1_if.d_valid}) !== 2'b10) begin
                errors++;
                $display("FAIL d_route src=%0h in0_valid=%0b in1_valid=%0b", src, in0_if.d_valid, in1_if.d_valid);
            end
            sb_d_step();
        end
        @(negedge clk);
        out_if.d_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive_a(0, 1'b0, OP_GET, 3'd0, 2'd0, 30'h0, 8'h0);
        drive_a(1, 1'b0, OP_GET, 3'd0, 2'd0, 30'h0, 8'h0);
        in0_if.a_param = 3'd0; in0_if.a_mask = 1'b1; in0_if.d_ready = 1'b1;
        in1_if.a_param = 3'd0; in1_if.a_mask = 1'b1; in1_if.d_ready = 1'b1;
        out_if.a_ready = 1'b1; out_if.d_valid = 1'b0; out_if.d_opcode = OP_ACK; out_if.d_param = 2'd0;
        out_if.d_size = 3'd0; out_if.d_source = 3'd0; out_if.d_sink = 1'b0; out_if.d_addr_lo = 1'b0;
        out_if.d_data = 8'h0; out_if.d_error = 1'b0;
        #1 rst_n = 1'b0;
        drive_a(0, 1'b1, OP_GET, 3'd0, 2'd1, 30'h100, 8'h0);
        out_if.d_valid = 1'b1;
        #1;
        checks++;
        if ({out_if.a_valid, in0_if.a_ready, in1_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got a_v=%0b a_r0=%0b a_r1=%0b d_v0=%0b d_v1=%0b d_r=%0b want all 0",
                     out_if.a_valid, in0_if.a_ready, in1_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready);
        end
        repeat (2) @(negedge clk);
        in0_if.a_valid = 1'b0;
        out_if.d_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_a(0, 1'b1, OP_GET, 3'd0, 2'd1, 30'h100, 8'h0);
        a_q.push_back(mk_a(3'b001, 30'h100, 8'h0));
        #1;
        checks++;
        if ({out_if.a_valid, in0_if.a_ready, in1_if.a_ready} !== 3'b110 || out_if.a_source !== 3'b001) begin
            errors++;
            $display("FAIL single_grant got a_v=%0b r0=%0b r1=%0b src=%0h want 1 1 0 src=1",
                     out_if.a_valid, in0_if.a_ready, in1_if.a_ready, out_if.a_source);
        end
        sb_a_step();
        @(negedge clk);
        in0_if.a_valid = 1'b0;
        #1;
        checks++;
        if (out_if.a_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release got a_valid=%0b want 0", out_if.a_valid);
        end
        send_d(3'b001, OP_ACKD, 3'd0, 8'h5A);
    endtask

    // Round-robin pointer is 1 here after the single in0 request.
    task automatic test_alternate();
        logic rr_m = 1'b1;
        int   k0 = 0;
        int   k1 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_a(0, 1'b1, OP_GET, 3'd0, 2'd2, 30'h200 + 30'(k0), 8'h0);
            drive_a(1, 1'b1, OP_GET, 3'd0, 2'd3, 30'h300 + 30'(k1), 8'h0);
            if (rr_m) a_q.push_back(mk_a(3'b111, 30'h300 + 30'(k1), 8'h0));
            else      a_q.push_back(mk_a(3'b010, 30'h200 + 30'(k0), 8'h0));
            #1;
            checks++;
            if (out_if.a_valid !== 1'b1 || out_if.a_source[2] !== rr_m) begin
                errors++;
                $display("FAIL alt_grant cycle=%0d got a_v=%0b winner=%0b want 1 winner=%0b", i, out_if.a_valid, out_if.a_source[2], rr_m);
            end
            sb_a_step();
            if (rr_m) k1++; else k0++;
            rr_m = ~rr_m;
        end
        @(negedge clk);
        in0_if.a_valid = 1'b0;
        in1_if.a_valid = 1'b0;
        send_d(3'b010, OP_ACK, 3'd0, 8'h00);
        send_d(3'b010, OP_ACK, 3'd0, 8'h00);
        send_d(3'b111, OP_ACK, 3'd0, 8'h00);
        send_d(3'b111, OP_ACK, 3'd0, 8'h00);
    endtask

    task automatic test_burst();
        @(negedge clk);
        drive_a(0, 1'b1, OP_PUTF, 3'd2, 2'd0, 30'h400, 8'h10);
        a_q.push_back(mk_a(3'b000, 30'h400, 8'h10));
        #1;
        checks++;
        if (in0_if.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_start got in0_a_ready=%0b want 1", in0_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        in0_if.a_data = 8'h11;
        a_q.push_back(mk_a(3'b000, 30'h400, 8'h11));
        drive_a(1, 1'b1, OP_GET, 3'd0, 2'd0, 30'h500, 8'h0);
        #1;
        checks++;
        if (in1_if.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL burst_lock1 got in1_a_ready=%0b want 0", in1_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        out_if.a_ready = 1'b0;
        in0_if.a_data = 8'h12;
        a_q.push_back(mk_a(3'b000, 30'h400, 8'h12));
        #1;
        checks++;
        if ({in0_if.a_ready, in1_if.a_ready, out_if.a_valid, out_if.a_source[2]} !== 4'b0010) begin
            errors++;
            $display("FAIL burst_stall got r0=%0b r1=%0b a_v=%0b winner=%0b want 0 0 1 0",
                     in0_if.a_ready, in1_if.a_ready, out_if.a_valid, out_if.a_source[2]);
        end
        sb_a_step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_if.a_ready = 1'b1;
            if (i == 1) begin
                in0_if.a_data = 8'h13;
                a_q.push_back(mk_a(3'b000, 30'h400, 8'h13));
            end
            #1;
            checks++;
            if (in1_if.a_ready !== 1'b0) begin
                errors++;
                $display("FAIL burst_lock2 step=%0d got in1_a_ready=%0b want 0", i, in1_if.a_ready);
            end
            sb_a_step();
        end
        @(negedge clk);
        in0_if.a_valid = 1'b0;
        a_q.push_back(mk_a(3'b100, 30'h500, 8'h0));
        #1;
        checks++;
        if (in1_if.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_handover got in1_a_ready=%0b want 1", in1_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        in1_if.a_valid = 1'b0;
        send_d(3'b000, OP_ACK, 3'd2, 8'h00);
        send_d(3'b100, OP_ACKD, 3'd0, 8'h77);
    endtask

    task automatic test_inflight();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_a(1, 1'b1, OP_GET, 3'd0, 2'd2, 30'h600 + 30'((i < 2) ? i : 2), 8'h0);
            if (i < 2) a_q.push_back(mk_a(3'b110, 30'h600 + 30'(i), 8'h0));
            #1;
            checks++;
            if (in1_if.a_ready !== (i < 2)) begin
                errors++;
                $display("FAIL inflight_cap cycle=%0d got in1_a_ready=%0b want %0b", i, in1_if.a_ready, (i < 2));
            end
            sb_a_step();
        end
        @(negedge clk);
        out_if.d_valid = 1'b1; out_if.d_opcode = OP_ACKD; out_if.d_size = 3'd0;
        out_if.d_source = 3'b110; out_if.d_data = 8'hA1;
        d_q.push_back(mk_d(3'b110, OP_ACKD, 8'hA1));
        #1;
        checks++;
        if (in1_if.a_ready !== 1'b0 || in1_if.d_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_dcycle got in1_a_ready=%0b in1_d_valid=%0b want 0 1", in1_if.a_ready, in1_if.d_valid);
        end
        sb_d_step();
        sb_a_step();
        @(negedge clk);
        out_if.d_valid = 1'b0;
        a_q.push_back(mk_a(3'b110, 30'h602, 8'h0));
        #1;
        checks++;
        if (in1_if.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL inflight_release got in1_a_ready=%0b want 1", in1_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        in1_if.a_valid = 1'b0;
        send_d(3'b110, OP_ACKD, 3'd0, 8'hA2);
        send_d(3'b110, OP_ACKD, 3'd0, 8'hA3);
    endtask

    task automatic test_dbeats();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int   b = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_a(0, 1'b1, OP_GET, (i == 0) ? 3'd2 : 3'd0, 2'd0, 30'h800 + 30'(i), 8'h0);
            if (i < 2) a_q.push_back(mk_a(3'b000, 30'h800 + 30'(i), 8'h0));
            #1;
            checks++;
            if (in0_if.a_ready !== (i < 2)) begin
                errors++;
                $display("FAIL dbeat_issue cycle=%0d got in0_a_ready=%0b want %0b", i, in0_if.a_ready, (i < 2));
            end
            sb_a_step();
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in0_if.d_ready = pat[i];
            out_if.d_valid = 1'b1; out_if.d_opcode = OP_ACKD; out_if.d_size = 3'd2;
            out_if.d_source = 3'b000; out_if.d_data = 8'hC0 + 8'(b);
            if (pat[i]) d_q.push_back(mk_d(3'b000, OP_ACKD, 8'hC0 + 8'(b)));
            #1;
            checks++;
            if (out_if.d_ready !== pat[i] || in0_if.a_ready !== 1'b0) begin
                errors++;
                $display("FAIL dbeat_ready cycle=%0d got d_ready=%0b in0_a_ready=%0b want %0b 0",
                         i, out_if.d_ready, in0_if.a_ready, pat[i]);
            end
            sb_d_step();
            if (pat[i]) b++;
        end
        @(negedge clk);
        out_if.d_valid = 1'b0;
        in0_if.d_ready = 1'b1;
        a_q.push_back(mk_a(3'b000, 30'h802, 8'h0));
        #1;
        checks++;
        if (in0_if.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL dbeat_release got in0_a_ready=%0b want 1", in0_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        in0_if.a_valid = 1'b0;
        send_d(3'b000, OP_ACKD, 3'd0, 8'hD1);
        send_d(3'b000, OP_ACKD, 3'd0, 8'hD2);
    endtask

    task automatic test_reset_burst();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_a(0, 1'b1, OP_PUTF, 3'd2, 2'd1, 30'h900, 8'h20 + 8'(i));
            a_q.push_back(mk_a(3'b001, 30'h900, 8'h20 + 8'(i)));
            #1;
            sb_a_step();
        end
        @(negedge clk);
        in0_if.a_data = 8'h22;
        out_if.d_valid = 1'b1; out_if.d_opcode = OP_ACK; out_if.d_source = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_if.a_valid, in0_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready} !== 5'b0) begin
            errors++;
            $display("FAIL rst_burst_outputs got a_v=%0b r0=%0b d_v0=%0b d_v1=%0b d_r=%0b want all 0",
                     out_if.a_valid, in0_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready);
        end
        sb_a_step();
        repeat (2) @(negedge clk);
        in0_if.a_valid = 1'b0;
        out_if.d_valid = 1'b0;
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j != 0) @(negedge clk);
            drive_a(1, 1'b1, OP_PUTF, 3'd2, 2'd0, 30'hA00, 8'h30 + 8'(j));
            a_q.push_back(mk_a(3'b100, 30'hA00, 8'h30 + 8'(j)));
            #1;
            checks++;
            if (in1_if.a_ready !== 1'b1 || out_if.a_source[2] !== 1'b1) begin
                errors++;
                $display("FAIL rst_fresh_burst beat=%0d got in1_a_ready=%0b winner=%0b want 1 1", j, in1_if.a_ready, out_if.a_source[2]);
            end
            sb_a_step();
        end
        @(negedge clk);
        in1_if.a_valid = 1'b0;
        drive_a(0, 1'b1, OP_GET, 3'd0, 2'd0, 30'hB00, 8'h0);
        a_q.push_back(mk_a(3'b000, 30'hB00, 8'h0));
        #1;
        checks++;
        if (in0_if.a_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_burst_end got in0_a_ready=%0b want 1", in0_if.a_ready);
        end
        sb_a_step();
        @(negedge clk);
        in0_if.a_valid = 1'b0;
        send_d(3'b100, OP_ACK, 3'd2, 8'h00);
        send_d(3'b000, OP_ACKD, 3'd0, 8'hE1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_inflight();
        test_dbeats();
        test_reset_burst();
        checks++;
        if (a_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got a_left=%0d d_left=%0d want 0 0", a_q.size(), d_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
